// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, data word and ALU arbiter helpers.
// Imported by the datapath and by the ALU arbiter slice.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } alu_req_t;

  localparam int ALU_LOCK_W = 4;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selection for the shared ALU.
// Lock hold first, then single request, then round-robin tie-break.
module alu_arb_pick
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock_act,
  input  alu_req_t              lock_own,
  input  logic [ALU_LOCK_W-1:0] lock_cnt,
  input  alu_req_t              last_gnt,
  output logic                  gnt0,
  output logic                  gnt1
);

  localparam logic [ALU_LOCK_W-1:0] MAX_C =
    ALU_LOCK_W'(MAX_LOCK);

  logic own_req;
  logic oth_req;
  logic hold;

  assign own_req = (lock_own == REQ0) ? req0 : req1;
  assign oth_req = (lock_own == REQ0) ? req1 : req0;
  assign hold = lock_act && own_req &&
                !(lock_cnt >= MAX_C && oth_req);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      hold: begin
        gnt0 = (lock_own == REQ0);
        gnt1 = (lock_own == REQ1);
      end
      !hold && req0 && !req1: gnt0 = 1'b1;
      !hold && !req0 && req1: gnt1 = 1'b1;
      !hold && req0 && req1: begin
        gnt0 = (last_gnt == REQ1);
        gnt1 = (last_gnt == REQ0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with
// round-robin arbitration, bounded lock and per-requester results.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   req0,
  input  logic   lock0,
  input  aluop_t ops0,
  input  word_t  a0,
  input  word_t  b0,
  output logic   gnt0,
  output logic   done0,
  output word_t  out0,
  output logic   zero0,
  output logic   neg0,
  output logic   ovf0,
  input  logic   req1,
  input  logic   lock1,
  input  aluop_t ops1,
  input  word_t  a1,
  input  word_t  b1,
  output logic   gnt1,
  output logic   done1,
  output word_t  out1,
  output logic   zero1,
  output logic   neg1,
  output logic   ovf1,
  output aluop_t alu_ops,
  output word_t  alu_a,
  output word_t  alu_b,
  input  word_t  alu_out,
  input  logic   alu_zero,
  input  logic   alu_negative,
  input  logic   alu_overflow
);

  alu_req_t              last_gnt;
  alu_req_t              lock_own;
  logic                  lock_act;
  logic [ALU_LOCK_W-1:0] lock_cnt;

  logic     gnt_any;
  alu_req_t gnt_who;
  logic     gnt_lock;

  alu_arb_pick #(.MAX_LOCK(MAX_LOCK)) u_pick (
    .req0     (req0),
    .req1     (req1),
    .lock_act (lock_act),
    .lock_own (lock_own),
    .lock_cnt (lock_cnt),
    .last_gnt (last_gnt),
    .gnt0     (gnt0),
    .gnt1     (gnt1)
  );

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_who  = gnt1 ? REQ1 : REQ0;
  assign gnt_lock = gnt1 ? lock1 : lock0;

  always_comb begin
    alu_ops = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (gnt0) begin
      alu_ops = ops0;
      alu_a   = a0;
      alu_b   = b0;
    end else if (gnt1) begin
      alu_ops = ops1;
      alu_a   = a1;
      alu_b   = b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      done0    <= 1'b0;
      out0     <= '0;
      zero0    <= 1'b0;
      neg0     <= 1'b0;
      ovf0     <= 1'b0;
      done1    <= 1'b0;
      out1     <= '0;
      zero1    <= 1'b0;
      neg1     <= 1'b0;
      ovf1     <= 1'b0;
      last_gnt <= REQ1;
      lock_act <= 1'b0;
      lock_own <= REQ0;
      lock_cnt <= '0;
    end else begin
      done0 <= gnt0;
      done1 <= gnt1;
      if (gnt0) begin
        out0  <= alu_out;
        zero0 <= alu_zero;
        neg0  <= alu_negative;
        ovf0  <= alu_overflow;
      end
      if (gnt1) begin
        out1  <= alu_out;
        zero1 <= alu_zero;
        neg1  <= alu_negative;
        ovf1  <= alu_overflow;
      end
      if (gnt_any) begin
        last_gnt <= gnt_who;
      end
      if (gnt_any && gnt_lock) begin
        if (lock_act && lock_own == gnt_who) begin
          // saturate so a long idle-peer run never wraps
          if (lock_cnt != '1) begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end else begin
          lock_act <= 1'b1;
          lock_own <= gnt_who;
          lock_cnt <= ALU_LOCK_W'(1);
        end
      end else begin
        lock_act <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// A small behavioural ALU closes the loop on the alu ports.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   req0, lock0, req1, lock1;
  aluop_t ops0, ops1;
  word_t  a0, b0, a1, b1;
  logic   gnt0, done0, zero0, neg0, ovf0;
  logic   gnt1, done1, zero1, neg1, ovf1;
  word_t  out0, out1;
  aluop_t alu_ops;
  word_t  alu_a, alu_b, alu_out;
  logic   alu_zero, alu_negative, alu_overflow;

  int n_vec;
  int n_bad;

  alu_arbiter #(.MAX_LOCK(4)) dut (
    .CLK          (clk),
    .nRST         (rst_n),
    .req0         (req0),
    .lock0        (lock0),
    .ops0         (ops0),
    .a0           (a0),
    .b0           (b0),
    .gnt0         (gnt0),
    .done0        (done0),
    .out0         (out0),
    .zero0        (zero0),
    .neg0         (neg0),
    .ovf0         (ovf0),
    .req1         (req1),
    .lock1        (lock1),
    .ops1         (ops1),
    .a1           (a1),
    .b1           (b1),
    .gnt1         (gnt1),
    .done1        (done1),
    .out1         (out1),
    .zero1        (zero1),
    .neg1         (neg1),
    .ovf1         (ovf1),
    .alu_ops      (alu_ops),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_ops)
      ALU_ADD: begin
        alu_out = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) &&
                       (alu_out[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_out = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) &&
                       (alu_out[31] != alu_a[31]);
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_zero     = (alu_out == '0);
    alu_negative = alu_out[31];
  end

  task automatic idle_inputs();
    req0 = 0; lock0 = 0; ops0 = ALU_ADD; a0 = 0; b0 = 0;
    req1 = 0; lock1 = 0; ops1 = ALU_ADD; a1 = 0; b1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if ({done0, done1, out0, out1} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_regs got d0=%b d1=%b o0=%h o1=%h want 0",
               done0, done1, out0, out1);
    end
    n_vec++;
    if ({gnt0, gnt1} !== 2'b00 || alu_ops !== ALU_ADD ||
        alu_a !== 0 || alu_b !== 0) begin
      n_bad++;
      $display("FAIL reset_idle got g=%b%b op=%0d a=%h b=%h want 00 ADD 0 0",
               gnt0, gnt1, alu_ops, alu_a, alu_b);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1; ops0 = ALU_ADD; a0 = 5; b0 = 7;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10 || alu_a !== 5 || alu_b !== 7) begin
      n_bad++;
      $display("FAIL single_gnt got g=%b%b a=%h b=%h want 10 5 7",
               gnt0, gnt1, alu_a, alu_b);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done0 !== 1 || out0 !== 32'd12 || zero0 !== 0 ||
        done1 !== 0 || out1 !== 0) begin
      n_bad++;
      $display("FAIL single_res got d0=%b o0=%h z0=%b d1=%b o1=%h want 1 c 0 0 0",
               done0, out0, zero0, done1, out1);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    req0 = 1; ops0 = ALU_SUB; a0 = 3; b0 = 3;
    req1 = 1; ops1 = ALU_OR; a1 = 32'hF0; b1 = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      n_vec++;
      if ({gnt0, gnt1} !== exp) begin
        n_bad++;
        $display("FAIL rr_gnt%0d got %b%b want %b", i, gnt0, gnt1, exp);
      end
      @(negedge clk);
    end
    n_vec++;
    if (out0 !== 0 || zero0 !== 1 || out1 !== 32'hFF) begin
      n_bad++;
      $display("FAIL rr_res got o0=%h z0=%b o1=%h want 0 1 ff",
               out0, zero0, out1);
    end
  endtask

  task automatic test_lock_bound();
    logic [1:0] exp;
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i < 4) ? 2'b10 : (i == 4) ? 2'b01 : 2'b10;
      n_vec++;
      if ({gnt0, gnt1} !== exp) begin
        n_bad++;
        $display("FAIL lock_gnt%0d got %b%b want %b", i, gnt0, gnt1, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock_saturate();
    int bad;
    do_reset();
    req0 = 1; lock0 = 1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (gnt0 !== 1) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL sat_run got %0d missed grants want 0", bad);
    end
    req1 = 1;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_bad++;
      $display("FAIL sat_switch got %b%b want 01", gnt0, gnt1);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    req1 = 1; ops1 = ALU_OR; a1 = 32'hF0; b1 = 32'h0F;
    @(negedge clk);
    req1 = 0;
    req0 = 1; ops0 = ALU_ADD; a0 = 32'h7FFFFFFF; b0 = 1;
    @(posedge clk); #1;
    n_vec++;
    if (out0 !== 32'h80000000 || ovf0 !== 1 || neg0 !== 1 ||
        zero0 !== 0 || done0 !== 1) begin
      n_bad++;
      $display("FAIL ovf_res got o0=%h v=%b n=%b z=%b d=%b want 80000000 1 1 0 1",
               out0, ovf0, neg0, zero0, done0);
    end
    n_vec++;
    if (out1 !== 32'hFF || done1 !== 0 || zero1 !== 0 || ovf1 !== 0) begin
      n_bad++;
      $display("FAIL ovf_hold1 got o1=%h d1=%b z1=%b v1=%b want ff 0 0 0",
               out1, done1, zero1, ovf1);
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++;
      $display("FAIL drop_first got %b%b want 10", gnt0, gnt1);
    end
    @(negedge clk);
    req0 = 0;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_gnt1 got %b%b want 01", gnt0, gnt1);
    end
    @(negedge clk);
    req0 = 1; lock0 = 0;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++;
      $display("FAIL drop_rr0 got %b%b want 10", gnt0, gnt1);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_rr1 got %b%b want 01", gnt0, gnt1);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    req0 = 1; ops0 = ALU_ADD; a0 = 5; b0 = 7;
    @(posedge clk); #1;
    n_vec++;
    if (done0 !== 1 || out0 !== 32'd12) begin
      n_bad++;
      $display("FAIL arst_pre got d0=%b o0=%h want 1 c", done0, out0);
    end
    #1 rst_n = 0;
    #1;
    n_vec++;
    if (done0 !== 0 || done1 !== 0 || out0 !== 0 || out1 !== 0) begin
      n_bad++;
      $display("FAIL arst_clr got d0=%b d1=%b o0=%h o1=%h want 0",
               done0, done1, out0, out1);
    end
    @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1; ops1 = ALU_OR; a1 = 1; b1 = 2;
    #1;
    n_vec++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++;
      $display("FAIL arst_tie got %b%b want 10", gnt0, gnt1);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done0 !== 1 || done1 !== 0 || out0 !== 32'd12) begin
      n_bad++;
      $display("FAIL arst_post got d0=%b d1=%b o0=%h want 1 0 c",
               done0, done1, out0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock_bound();
    test_lock_saturate();
    test_overflow();
    test_lock_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
